// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. Owns the fetch PC, drives the instruction memory
//   address, captures the returned byte and buffers {pc, byte} pairs in a
//   2-entry prefetch queue. The queue feeds decode over a valid/ready handshake.
//   A redirect flushes the queue and restarts fetch at the target.
//
// Ports
//   clk_i            clock, all state on rising edge
//   rst_n_i          asynchronous active-low reset
//   im_addr_o        instruction memory address (the fetch PC register)
//   im_data_i        instruction memory read data, combinational from im_addr_o
//   fetch_en_i       1 = fetch allowed this cycle, 0 = hold PC, no push
//   redirect_valid_i load redirect_pc_i into the fetch PC, flush the queue
//   redirect_pc_i    redirect target
//   instr_valid_o    queue head valid
//   instr_o          queue head instruction byte
//   instr_pc_o       address the head byte was fetched from
//   instr_ready_i    decode accepts the head this cycle
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DATA_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic [ADDR_W-1:0] im_addr_o,
    input  logic [DATA_W-1:0] im_data_i,
    input  logic              fetch_en_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              instr_valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    input  logic              instr_ready_i
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [1:0]      entry_q;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              pop, push;

    // A full queue may still accept a byte when the head leaves in the same
    // cycle, which keeps throughput at one instruction per cycle.
    assign pop  = (count_q != 2'd0) & instr_ready_i;
    assign push = fetch_en_i & ~redirect_valid_i & ((count_q != 2'd2) | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect_valid_i) begin
            // A head popped this cycle is already consumed by decode; everything
            // else in the queue belongs to the wrong path and is dropped.
            fetch_pc_d = redirect_pc_i;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);  // wraps silently
                wr_ptr_d   = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            entry_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                entry_q[wr_ptr_q] <= '{pc: fetch_pc_q, data: im_data_i};
            end
        end
    end

    // No bypass: a byte fetched at edge N is visible only after edge N.
    assign im_addr_o     = fetch_pc_q;
    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = entry_q[rd_ptr_q].data;
    assign instr_pc_o    = entry_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] im_addr, im_data, redirect_pc, instr, instr_pc;
    logic       fetch_en, redirect_valid, instr_valid, instr_ready;

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign im_data = mem[im_addr];

    fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .im_addr_o(im_addr), .im_data_i(im_data),
        .fetch_en_i(fetch_en), .redirect_valid_i(redirect_valid),
        .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    int checks = 0, failures = 0;

    // Reference model: a queue of fetched {pc, byte} pairs plus the fetch PC.
    typedef struct packed { logic [7:0] pc; logic [7:0] data; } ent_t;
    ent_t       mq[$];
    logic [7:0] mpc;

    task automatic model_reset();
        mq.delete();
        mpc = 8'h00;
    endtask

    // Drive one cycle of inputs, advance the model with the rules of the
    // stage, and return 1 time unit after the rising edge.
    task automatic step(input logic fe, input logic rv, input logic [7:0] rpc,
                        input logic rdy);
        bit         pop, push;
        logic [7:0] d;
        fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
        pop  = (mq.size() > 0) && rdy;
        push = fe && !rv && ((mq.size() < 2) || pop);
        d    = mem[mpc];
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc = rpc;
        end else if (push) begin
            mq.push_back('{pc: mpc, data: d});
            mpc = mpc + 8'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic fill_mem_linear();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    endtask

    task automatic test_reset();
        fill_mem_linear();
        rst_n = 1'b0;
        fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        #2;
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h00 || instr !== 8'h00 || instr_pc !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: valid=%b im_addr=%h instr=%h instr_pc=%h, required 0 00 00 00",
                     instr_valid, im_addr, instr, instr_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_release: valid=%b im_addr=%h, required 0 00", instr_valid, im_addr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr !== 8'(k + 8'h10)) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, instr_valid, instr_pc, instr, 8'(k), 8'(k + 8'h10));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if (im_addr !== 8'h02 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            failures++;
            $display("FAIL stall_full: im_addr=%h valid=%b pc=%h, required 02 1 00",
                     im_addr, instr_valid, instr_pc);
        end
        for (int k = 1; k <= 2; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(k)) begin
                failures++;
                $display("FAIL stall_drain_%0d: valid=%b pc=%h, required 1 %h",
                         k, instr_valid, instr_pc, 8'(k));
            end
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);  // queue now holds pc 5 and 6
        checks++;
        if (instr_pc !== 8'h05 || im_addr !== 8'h07 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_setup: pc=%h im_addr=%h valid=%b, required 05 07 1",
                     instr_pc, im_addr, instr_valid);
        end
        step(1'b1, 1'b1, 8'h40, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h40) begin
            failures++;
            $display("FAIL redir_bubble: valid=%b im_addr=%h, required 0 40", instr_valid, im_addr);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 8'(8'h40 + k) || instr !== 8'(8'h50 + k)) begin
                failures++;
                $display("FAIL redir_target_%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, instr_valid, instr_pc, instr, 8'(8'h40 + k), 8'(8'h50 + k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
        step(1'b1, 1'b1, 8'hFE, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc[k] || instr !== 8'(exp_pc[k] + 8'h10)) begin
                failures++;
                $display("FAIL wrap_%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, instr_valid, instr_pc, instr, exp_pc[k], 8'(exp_pc[k] + 8'h10));
            end
        end
    endtask

    task automatic test_fetch_disable();
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);  // pc 0 and 1 queued
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h01 || im_addr !== 8'h02) begin
            failures++;
            $display("FAIL fe0_drain: valid=%b pc=%h im_addr=%h, required 1 01 02",
                     instr_valid, instr_pc, im_addr);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h02) begin
            failures++;
            $display("FAIL fe0_empty: valid=%b im_addr=%h, required 0 02", instr_valid, im_addr);
        end
        step(1'b0, 1'b1, 8'h20, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h20) begin
            failures++;
            $display("FAIL fe0_redirect: valid=%b im_addr=%h, required 0 20", instr_valid, im_addr);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h20) begin
            failures++;
            $display("FAIL fe0_hold: valid=%b im_addr=%h, required 0 20", instr_valid, im_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || im_addr !== 8'h00 || instr !== 8'h00 || instr_pc !== 8'h00) begin
            failures++;
            $display("FAIL async_reset: valid=%b im_addr=%h instr=%h pc=%h, required 0 00 00 00",
                     instr_valid, im_addr, instr, instr_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || im_addr !== 8'h01) begin
            failures++;
            $display("FAIL async_restart: valid=%b pc=%h im_addr=%h, required 1 00 01",
                     instr_valid, instr_pc, im_addr);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, ($urandom % 10) == 0, 8'($urandom), ($urandom % 3) != 0);
            checks++;
            if (instr_valid !== (mq.size() > 0) || im_addr !== mpc) begin
                failures++; bad++;
                if (bad < 10)
                    $display("FAIL rand_ctl_%0d: valid=%b im_addr=%h, required %b %h",
                             n, instr_valid, im_addr, mq.size() > 0, mpc);
            end
            if (mq.size() > 0) begin
                checks++;
                if (instr !== mq[0].data || instr_pc !== mq[0].pc) begin
                    failures++; bad++;
                    if (bad < 10)
                        $display("FAIL rand_head_%0d: instr=%h pc=%h, required %h %h",
                                 n, instr, instr_pc, mq[0].data, mq[0].pc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pop();
        test_wrap();
        test_fetch_disable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the memory address bus, captures the returned 8-bit instruction byte, and buffers it in a 2-entry prefetch queue. The queue feeds the decode stage over a valid/ready handshake. Control-flow redirects (branch/jump) flush the queue and restart fetch at the target.

## Interface
- ADDR_W, 8, program counter / memory address width
- DATA_W, 8, instruction byte width
- RESET_PC, 8'h00, fetch address after reset
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- im_addr  output  ADDR_W  address to instruction memory; equals fetch_pc register
- im_data  input  DATA_W  instruction memory read data, combinational from im_addr, valid before next rising edge
- fetch_en  input  1  1 = fetch allowed this cycle; 0 = hold fetch_pc, no push
- redirect_valid  input  1  pulse: load new fetch address, flush queue
- redirect_pc  input  ADDR_W  redirect target
- instr_valid  output  1  queue head valid
- instr  output  DATA_W  queue head instruction byte
- instr_pc  output  ADDR_W  address the head byte was fetched from
- instr_ready  input  1  decode accepts head this cycle

## Operation
- State: fetch_pc (ADDR_W), 2-entry FIFO of {pc, byte}, occupancy count 0..2, read/write pointers.
- im_addr = fetch_pc continuously (no registered delay).
- pop = instr_valid & instr_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop). Push writes {fetch_pc, im_data}; fetch_pc <= fetch_pc + 1, modulo 2^ADDR_W (8'hFF -> 8'h00, no flag).
- Full and popping in same cycle: push permitted, count stays 2 (sustained 1 instr/cycle).
- Empty: no bypass; pushed entry becomes visible on next cycle.
- redirect_valid = 1 (highest priority): fetch_pc <= redirect_pc; queue cleared (count 0); no push that cycle. A head accepted by pop in the same cycle counts as consumed; all other entries discarded.
- fetch_en = 0 with redirect_valid = 1: redirect still applied.
- fetch_en = 0 alone: fetch_pc held, queue drains normally via pop.
- instr, instr_pc driven from head entry; values when instr_valid = 0 are unspecified and not checked.
- Reset (rst_n = 0, any time incl. mid-redirect or queue full): fetch_pc = RESET_PC, count = 0, pointers = 0, instr_valid = 0, instr = 0, instr_pc = 0, im_addr = RESET_PC; takes effect immediately, asynchronously.

## Timing
- Reset release before edge 0: im_addr = RESET_PC; after edge 0 (fetch_en = 1) instr_valid = 1, instr = mem[RESET_PC], instr_pc = RESET_PC.
- Fetch-to-decode latency: 1 cycle (byte sampled at edge N visible after edge N).
- Redirect asserted during cycle N: after edge N im_addr = target, instr_valid = 0; after edge N+1 instr_valid = 1, instr_pc = target. Redirect bubble = 1 cycle.
- instr_ready = 0 from full: queue holds 2 entries, fetch_pc frozen, im_addr stable.
- Throughput with instr_ready held 1: one instruction per cycle, no bubbles.
- Outputs change only on rising clk edge or asynchronous reset assertion.

## Test plan
- Reset then fetch_en = 1, instr_ready = 1, mem[i] = i+8'h10 -> instr_pc 0,1,2,3 on consecutive cycles with instr 8'h10,8'h11,8'h12,8'h13; first valid one cycle after release.
- instr_ready = 0 for 5 cycles from PC 0 -> count saturates at 2 (pc 0,1 queued), im_addr holds 8'h02; on instr_ready = 1, instr_pc 0,1,2 delivered back to back with no gap.
- Redirect to 8'h40 while queue holds pc 5,6 and pop asserted -> pc 5 consumed, pc 6 dropped, one cycle instr_valid = 0, then instr_pc 8'h40, 8'h41.
- Redirect to 8'hFE, run 4 cycles -> instr_pc 8'hFE, 8'hFF, 8'h00, 8'h01 (wrap, no stall).
- fetch_en = 0 with 2 queued, ready = 1 -> 2 instrs delivered, then instr_valid = 0, im_addr unchanged; fetch_en = 0 plus redirect to 8'h20 -> im_addr = 8'h20 next cycle.
- Assert rst_n = 0 mid-stream with queue full, between clock edges -> instr_valid = 0, im_addr = RESET_PC immediately; after release, fetch restarts at RESET_PC.
